// File: rtl/btb.sv
// Branch target buffer: direct-mapped table giving a combinational taken/target
// hint for the fetch PC and learning from branches resolved in EX.
//
// Packed layout of branch_predict_i (branchpredict), MSB first:
//   [132:69] pc, [68:5] target_address, [4] is_mispredict, [3] is_taken,
//   [2] is_lower_16, [1] valid, [0] clear
// Packed layout of branch_predict_o (branchpredict_sbe), MSB first:
//   [66] valid, [65:2] predict_address, [1] predict_taken, [0] is_lower_16
module btb #(
  parameter int unsigned NR_ENTRIES              = 8,
  parameter int unsigned BITS_SATURATION_COUNTER = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic [63:0]  vpc_i,
  input  logic [132:0] branch_predict_i,
  output logic [66:0]  branch_predict_o
);

  localparam int unsigned IdxW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
  localparam int unsigned CntW = BITS_SATURATION_COUNTER;

  localparam logic [CntW-1:0] CntMax   = '1;
  localparam logic [CntW-1:0] CntWeakT = CntW'(1) << (CntW - 1);
  localparam logic [CntW-1:0] CntWeakN = CntWeakT - CntW'(1);

  // Unpacked update fields
  logic [63:0] upd_pc;
  logic [63:0] upd_target;
  logic        upd_mispredict;
  logic        upd_taken;
  logic        upd_lower;
  logic        upd_valid;
  logic        upd_clear;

  assign upd_pc         = branch_predict_i[132:69];
  assign upd_target     = branch_predict_i[68:5];
  assign upd_mispredict = branch_predict_i[4];
  assign upd_taken      = branch_predict_i[3];
  assign upd_lower      = branch_predict_i[2];
  assign upd_valid      = branch_predict_i[1];
  assign upd_clear      = branch_predict_i[0];

  // Mispredict flag is informational only; it never steers the table.
  logic unused_mispredict;
  assign unused_mispredict = upd_mispredict;

  // Table state
  logic            valid_q  [NR_ENTRIES];
  logic            valid_d  [NR_ENTRIES];
  logic [63:0]     pc_q     [NR_ENTRIES];
  logic [63:0]     pc_d     [NR_ENTRIES];
  logic [63:0]     target_q [NR_ENTRIES];
  logic [63:0]     target_d [NR_ENTRIES];
  logic            lower_q  [NR_ENTRIES];
  logic            lower_d  [NR_ENTRIES];
  logic [CntW-1:0] cnt_q    [NR_ENTRIES];
  logic [CntW-1:0] cnt_d    [NR_ENTRIES];

  logic [IdxW-1:0] lk_idx;
  logic [IdxW-1:0] upd_idx;
  logic            lk_hit;
  logic            upd_hit;

  assign lk_idx  = vpc_i[2 +: IdxW];
  assign upd_idx = upd_pc[2 +: IdxW];
  assign lk_hit  = valid_q[lk_idx] && (pc_q[lk_idx] == vpc_i);
  assign upd_hit = valid_q[upd_idx] && (pc_q[upd_idx] == upd_pc);

  // Lookup: reads only registered state, so an update is seen from the next cycle
  always_comb begin
    branch_predict_o = '0;
    if (lk_hit) begin
      branch_predict_o = {1'b1, target_q[lk_idx], cnt_q[lk_idx][CntW-1], lower_q[lk_idx]};
    end
  end

  // Next-state: one update per cycle, flush overrides it
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    target_d = target_q;
    lower_d  = lower_q;
    cnt_d    = cnt_q;

    if (upd_valid) begin
      if (upd_clear) begin
        valid_d[upd_idx] = 1'b0;
      end else if (upd_hit) begin
        // Train existing entry with a saturating counter
        if (upd_taken) begin
          if (cnt_q[upd_idx] != CntMax) cnt_d[upd_idx] = cnt_q[upd_idx] + CntW'(1);
          target_d[upd_idx] = upd_target;
        end else if (cnt_q[upd_idx] != '0) begin
          cnt_d[upd_idx] = cnt_q[upd_idx] - CntW'(1);
        end
        lower_d[upd_idx] = upd_lower;
      end else begin
        // Allocate, evicting whatever aliased into this slot
        valid_d[upd_idx]  = 1'b1;
        pc_d[upd_idx]     = upd_pc;
        lower_d[upd_idx]  = upd_lower;
        cnt_d[upd_idx]    = upd_taken ? CntWeakT : CntWeakN;
        target_d[upd_idx] = upd_taken ? upd_target : 64'h0;
      end
    end

    if (flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) valid_d[i] = 1'b0;
    end
  end

  // Table registers with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        pc_q[i]     <= '0;
        target_q[i] <= '0;
        lower_q[i]  <= 1'b0;
        cnt_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        valid_q[i]  <= valid_d[i];
        pc_q[i]     <= pc_d[i];
        target_q[i] <= target_d[i];
        lower_q[i]  <= lower_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_btb.sv
// Directed bench for btb: allocation, counter saturation, aliasing, clear,
// flush and asynchronous reset.
module tb_btb;

  logic         clk_i;
  logic         rst_ni;
  logic         flush_i;
  logic [63:0]  vpc_i;
  logic [132:0] branch_predict_i;
  logic [66:0]  branch_predict_o;

  logic [63:0] bp_pc;
  logic [63:0] bp_tgt;
  logic        bp_mis;
  logic        bp_taken;
  logic        bp_lower;
  logic        bp_valid;
  logic        bp_clear;

  int n_vec;
  int n_err;

  assign branch_predict_i = {bp_pc, bp_tgt, bp_mis, bp_taken, bp_lower, bp_valid, bp_clear};

  btb #(
    .NR_ENTRIES              (8),
    .BITS_SATURATION_COUNTER (2)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .vpc_i            (vpc_i),
    .branch_predict_i (branch_predict_i),
    .branch_predict_o (branch_predict_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [66:0] hit(input logic [63:0] addr, input logic taken,
                                      input logic lower);
    return {1'b1, addr, taken, lower};
  endfunction

  task automatic check(input string tag, input logic [66:0] exp);
    n_vec++;
    assert (branch_predict_o === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, branch_predict_o, exp);
    end
  endtask

  // Present an update; caller advances the clock
  task automatic upd_set(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                         input logic lower, input logic clr);
    bp_pc    = pc;
    bp_tgt   = tgt;
    bp_taken = taken;
    bp_lower = lower;
    bp_clear = clr;
    bp_mis   = 1'b1;
    bp_valid = 1'b1;
  endtask

  // Finish the current cycle and drop the update, 1 time unit past the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
    bp_valid = 1'b0;
    bp_clear = 1'b0;
    bp_mis   = 1'b0;
    flush_i  = 1'b0;
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                     input logic lower, input logic clr);
    upd_set(pc, tgt, taken, lower, clr);
    tick();
  endtask

  task automatic look(input logic [63:0] pc);
    vpc_i = pc;
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_ni   = 1'b0;
    flush_i  = 1'b0;
    vpc_i    = 64'h8000_0000;
    bp_pc    = '0;
    bp_tgt   = '0;
    bp_mis   = 1'b0;
    bp_taken = 1'b0;
    bp_lower = 1'b0;
    bp_valid = 1'b0;
    bp_clear = 1'b0;

    #1;
    check("reset_empty", '0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    look(64'h8000_0000);
    check("empty_after_reset", '0);

    // Allocate taken; same-cycle lookup still misses
    vpc_i = 64'h8000_0010;
    upd_set(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
    #1;
    check("alloc_same_cycle_miss", '0);
    tick();
    look(64'h8000_0010);
    check("alloc_hit", hit(64'h8000_0100, 1'b1, 1'b0));

    // Counter 10 -> 11 (saturates), then down
    upd(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
    upd(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
    upd(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b1, 1'b0);
    look(64'h8000_0010);
    check("sat_high_lower16", hit(64'h8000_0100, 1'b1, 1'b1));
    upd(64'h8000_0010, 64'hdead_beef, 1'b0, 1'b0, 1'b0);
    look(64'h8000_0010);
    check("nt_from_max_still_taken", hit(64'h8000_0100, 1'b1, 1'b0));
    upd(64'h8000_0010, 64'hdead_beef, 1'b0, 1'b0, 1'b0);
    look(64'h8000_0010);
    check("second_nt_not_taken", hit(64'h8000_0100, 1'b0, 1'b0));
    upd(64'h8000_0010, 64'hdead_beef, 1'b0, 1'b0, 1'b0);
    upd(64'h8000_0010, 64'hdead_beef, 1'b0, 1'b0, 1'b0);
    upd(64'h8000_0010, 64'hdead_beef, 1'b0, 1'b0, 1'b0);
    upd(64'h8000_0010, 64'h8000_0300, 1'b1, 1'b0, 1'b0);
    look(64'h8000_0010);
    check("sat_low_then_taken", hit(64'h8000_0300, 1'b0, 1'b0));
    upd(64'h8000_0010, 64'h8000_0400, 1'b1, 1'b0, 1'b0);
    look(64'h8000_0010);
    check("back_to_taken_new_target", hit(64'h8000_0400, 1'b1, 1'b0));

    // Aliasing: 0x...30 shares index 4 with 0x...10
    upd(64'h8000_0030, 64'h8000_0200, 1'b1, 1'b0, 1'b0);
    look(64'h8000_0010);
    check("alias_old_miss", '0);
    look(64'h8000_0030);
    check("alias_new_hit", hit(64'h8000_0200, 1'b1, 1'b0));
    upd(64'h8000_0030, 64'h0, 1'b0, 1'b0, 1'b0);
    look(64'h8000_0030);
    check("alias_fresh_weak_cnt", hit(64'h8000_0200, 1'b0, 1'b0));

    // Not-taken allocation zeroes the target
    upd(64'h8000_0040, 64'h0000_0123, 1'b0, 1'b1, 1'b0);
    look(64'h8000_0040);
    check("alloc_nt", hit(64'h0, 1'b0, 1'b1));
    upd(64'h8000_0040, 64'h8000_0500, 1'b1, 1'b1, 1'b0);
    look(64'h8000_0040);
    check("alloc_nt_then_taken", hit(64'h8000_0500, 1'b1, 1'b1));
    look(64'h8000_0030);
    check("other_index_untouched", hit(64'h8000_0200, 1'b0, 1'b0));

    // Clear
    upd(64'h8000_0040, 64'h0, 1'b0, 1'b0, 1'b1);
    look(64'h8000_0040);
    check("clear_miss", '0);

    // Flush wins over a concurrent allocation
    upd_set(64'h8000_0008, 64'h8000_0600, 1'b1, 1'b0, 1'b0);
    flush_i = 1'b1;
    tick();
    look(64'h8000_0008);
    check("flush_alloc_miss", '0);
    look(64'h8000_0030);
    check("flush_other_miss", '0);

    // Asynchronous reset between edges
    upd(64'h8000_0010, 64'h8000_0700, 1'b1, 1'b0, 1'b0);
    look(64'h8000_0010);
    check("prereset_hit", hit(64'h8000_0700, 1'b1, 1'b0));
    #1;
    rst_ni = 1'b0;
    #1;
    check("async_reset_clear", '0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    check("after_reset_still_miss", '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
